// File: rtl/console_tx.sv
// console_tx: memory-mapped console output. CPU byte writes to the data
// address are queued in a small FIFO and sent as 8N1 frames on tx. The
// status byte is readable at the adjacent address.
module console_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] DATA_ADDR    = 16'h005A,
  parameter logic [15:0] STATUS_ADDR  = 16'h005B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        selected,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;

  // Transmitter state
  tx_state_t        state_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;

  logic push_req;
  logic clear_req;
  logic fifo_empty;
  logic fifo_full;
  logic do_push;
  logic do_pop;
  logic bit_done;
  logic [7:0] status_byte;

  assign push_req   = write_en && (address == DATA_ADDR);
  assign clear_req  = write_en && (address == STATUS_ADDR);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  // Full/empty are taken from pre-edge state: a push into a full FIFO is
  // dropped even when the transmitter pops on the same edge.
  assign do_push    = push_req && !fifo_full;
  assign do_pop     = (state_reg == ST_IDLE) && !fifo_empty;
  assign bit_done   = (clk_cnt_reg == LAST_CLK);

  assign status_byte = {4'b0000, overflow_reg, (state_reg != ST_IDLE),
                        fifo_full, fifo_empty};
  assign selected    = (address == DATA_ADDR) || (address == STATUS_ADDR);
  assign data_out    = (address == STATUS_ADDR) ? status_byte : 8'h00;
  assign tx          = tx_reg;

  // FIFO data array, kept reset-free so it maps onto RAM
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_mem[tail_reg] <= data_in;
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A status write wins over a simultaneous overflow event.
      if (clear_req) begin
        overflow_reg <= 1'b0;
      end else if (push_req && fifo_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Serial transmitter: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg      <= 1'b1;
          clk_cnt_reg <= '0;
          if (do_pop) begin
            shift_reg <= fifo_mem[head_reg];
            tx_reg    <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
            state_reg   <= ST_DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            clk_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            clk_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_tx.sv
// Directed testbench for console_tx with CLKS_PER_BIT=4 and an 8-deep FIFO.
// A UART receiver model decodes tx into a queue of bytes.
module tb_console_tx;

  localparam int CPB = 4;
  localparam logic [15:0] DATA_A   = 16'h005A;
  localparam logic [15:0] STATUS_A = 16'h005B;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        selected;
  logic        tx;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx_shift;
  int         rx_cnt;
  int         bit_no;
  bit         rx_busy = 1'b0;
  logic       tx_prev = 1'b1;

  console_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8),
    .DATA_ADDR   (DATA_A),
    .STATUS_ADDR (STATUS_A)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .selected(selected),
    .tx      (tx)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    @(posedge clock);
    #1;
    write_en = 1'b0;
    address  = 16'h0000;
    $display("write addr=%04h data=%02h", a, d);
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp);
    @(negedge clock);
    address  = STATUS_A;
    write_en = 1'b0;
    #1;
    check_val(tag, data_out, exp);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_val("rx_count", rx_q.size(), n);
  endtask

  // Receiver model: samples each bit at mid-period on the falling clock edge
  always @(negedge clock) begin
    if (reset) begin
      rx_busy = 1'b0;
      tx_prev = 1'b1;
    end else if (!rx_busy) begin
      if (tx_prev && !tx) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
      tx_prev = tx;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        bit_no = rx_cnt / CPB;
        if (bit_no >= 1 && bit_no <= 8) begin
          rx_shift[bit_no-1] = tx;
        end else if (bit_no == 9) begin
          check_val("rx_stop_bit", tx, 1);
          rx_q.push_back(rx_shift);
          $display("rx byte=%02h", rx_shift);
          rx_busy = 1'b0;
        end
      end
      tx_prev = tx;
    end
  end

  logic [7:0] msg [10] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F,
                           8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

  initial begin
    logic [7:0] frame_byte;
    logic       exp_tx;
    int         base;
    bit         saw_low;

    reset    = 1'b1;
    address  = 16'h0000;
    write_en = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state and idle line
    read_status("reset_status", 8'h01);
    check_val("reset_sel_status", selected, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check_val("idle_tx", tx, 1);
    end
    @(negedge clock);
    address = 16'h1234;
    #1;
    check_val("other_sel", selected, 0);
    check_val("other_data", data_out, 8'h00);
    address = DATA_A;
    #1;
    check_val("data_sel", selected, 1);
    check_val("data_rd", data_out, 8'h00);

    // Single frame of 8'h48, checked bit-cycle by bit-cycle
    frame_byte = 8'h48;
    bus_write(DATA_A, frame_byte);
    @(negedge clock);
    address = STATUS_A;
    #1;
    check_val("pre_pop_tx", tx, 1);
    check_val("pre_pop_status", data_out, 8'h00);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i < 4)       exp_tx = 1'b0;
      else if (i < 36) exp_tx = frame_byte[(i-4)/4];
      else             exp_tx = 1'b1;
      check_val($sformatf("frame_tx[%0d]", i), tx, exp_tx);
      if (i == 10) check_val("busy_status", data_out, 8'h05);
    end
    read_status("after_frame_status", 8'h01);
    wait_rx(1, 10);
    check_val("frame_byte", rx_q[0], 8'h48);

    // Overflow: ten back-to-back writes into an 8-deep FIFO
    base = rx_q.size();
    for (int i = 0; i < 10; i++) bus_write(DATA_A, msg[i]);
    read_status("overflow_status", 8'h0E);
    bus_write(STATUS_A, 8'h5A);
    read_status("clear_status", 8'h06);
    wait_rx(base + 9, 9 * 45 + 50);
    for (int i = 0; i < 9; i++) begin
      if (base + i < rx_q.size())
        check_val($sformatf("msg_byte[%0d]", i), rx_q[base+i], msg[i]);
      else
        check_val($sformatf("msg_missing[%0d]", i), rx_q.size(), base + i + 1);
    end
    repeat (60) @(negedge clock);
    check_val("no_extra_frame", rx_q.size(), base + 9);
    read_status("post_overflow_status", 8'h01);

    // Reset in the middle of the data bits of a 3-byte burst
    base = rx_q.size();
    bus_write(DATA_A, 8'h11);
    bus_write(DATA_A, 8'h22);
    bus_write(DATA_A, 8'h33);
    repeat (12) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_val("reset_tx", tx, 1);
    reset = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check_val("reset_no_frames", saw_low, 0);
    check_val("reset_rx_count", rx_q.size(), base);
    read_status("reset_mid_status", 8'h01);

    // Pointer wrap: 20 bytes, one per frame
    base = rx_q.size();
    for (int i = 0; i < 20; i++) begin
      frame_byte = 8'(i * 37 + 5);
      bus_write(DATA_A, frame_byte);
      wait_rx(base + i + 1, 100);
      if (base + i < rx_q.size())
        check_val($sformatf("wrap_byte[%0d]", i), rx_q[base+i], frame_byte);
    end
    repeat (8) @(negedge clock);
    read_status("wrap_status", 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
